// File: rtl/ov7670_config_sequencer.sv
// Walks the OV7670 register ROM and issues one SCCB write per {reg,val} entry.
// Optional SCCB ready watchdog is enabled by defining SCCB_TIMEOUT_EN.
module ov7670_config_sequencer #(
    parameter int unsigned CLK_FREQ_HZ = 25_000_000,
    parameter int unsigned DELAY_MS    = 10
`ifdef SCCB_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic        sccb_start,
    output logic [7:0]  sccb_reg,
    output logic [7:0]  sccb_val,
    input  logic        sccb_ready,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  write_count
);

    // Handshake: sccb_start is asserted only in a cycle where sccb_ready is high;
    // the master takes the request on that clock edge and drops ready the cycle after.

    localparam logic [31:0] DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int          DLY_W        = $clog2(DELAY_CYCLES + 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(DELAY_CYCLES - 1);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FETCH     = 4'd1;
    localparam logic [3:0] DECODE    = 4'd2;
    localparam logic [3:0] WAIT_RDY  = 4'd3;
    localparam logic [3:0] HOLD      = 4'd4;
    localparam logic [3:0] WAIT_DONE = 4'd5;
    localparam logic [3:0] DELAY     = 4'd6;
    localparam logic [3:0] NEXT      = 4'd7;
    localparam logic [3:0] DONE      = 4'd8;

    logic [3:0]       state;
    logic [DLY_W-1:0] dly_cnt;

    assign sccb_start = (state == WAIT_RDY) && sccb_ready;

`ifdef SCCB_TIMEOUT_EN
    localparam int            WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic            in_wait;
    logic            wd_fire;

    // A ready arriving on the final cycle wins over the watchdog.
    assign in_wait = (state == WAIT_RDY) || (state == WAIT_DONE);
    assign wd_fire = in_wait && !sccb_ready && (wd_cnt == WD_LAST);
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst || !in_wait || sccb_ready || wd_fire) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rom_addr    <= '0;
            sccb_reg    <= '0;
            sccb_val    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            write_count <= '0;
            dly_cnt     <= '0;
`ifdef SCCB_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rom_addr    <= '0;
                        done        <= 1'b0;
                        write_count <= '0;
                        busy        <= 1'b1;
                        state       <= FETCH;
`ifdef SCCB_TIMEOUT_EN
                        err_q       <= 1'b0;
`endif
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (rom_data == 16'hFFFF) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (rom_data == 16'hFFF0) begin
                        dly_cnt <= '0;
                        state   <= DELAY;
                    end else begin
                        sccb_reg <= rom_data[15:8];
                        sccb_val <= rom_data[7:0];
                        state    <= WAIT_RDY;
                    end
                end
                WAIT_RDY: begin
                    if (sccb_ready) begin
                        if (write_count != 8'hFF) begin
                            write_count <= write_count + 8'd1;
                        end
                        state <= HOLD;
                    end
                end
                // Master ready is still settling the cycle after the request.
                HOLD: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (sccb_ready) begin
                        state <= NEXT;
                    end
                end
                DELAY: begin
                    if (dly_cnt == DLY_LAST) begin
                        state <= NEXT;
                    end else begin
                        dly_cnt <= dly_cnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (rom_addr == 8'hFF) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rom_addr <= rom_addr + 8'd1;
                        state    <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef SCCB_TIMEOUT_EN
            if (wd_fire) begin
                err_q <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ov7670_config_sequencer.sv
// Bench for ov7670_config_sequencer: ROM model, SCCB master model, write scoreboard.
// Define SCCB_TIMEOUT_EN to also exercise the ready watchdog.
module tb_ov7670_config_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        sccb_start;
    logic [7:0]  sccb_reg;
    logic [7:0]  sccb_val;
    logic        sccb_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  write_count;

    ov7670_config_sequencer #(
        .CLK_FREQ_HZ(1000),
        .DELAY_MS(10)
`ifdef SCCB_TIMEOUT_EN
        , .TIMEOUT_CYCLES(100)
`endif
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .sccb_start(sccb_start), .sccb_reg(sccb_reg), .sccb_val(sccb_val),
        .sccb_ready(sccb_ready), .busy(busy), .done(done), .err(err),
        .write_count(write_count)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- ROM model, 1-clk latency ----------------
    logic [15:0] rom_mem [256];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // ---------------- SCCB master model: ready low 20 clk after each request ----------------
    logic       hold_low;
    logic       rdy_int;
    logic [4:0] mdl_cnt;
    assign sccb_ready = rdy_int && !hold_low;
    always @(posedge clk) begin
        if (rst) begin
            rdy_int <= 1'b1;
            mdl_cnt <= '0;
        end else if (sccb_start && sccb_ready) begin
            rdy_int <= 1'b0;
            mdl_cnt <= 5'd20;
        end else if (mdl_cnt != 0) begin
            mdl_cnt <= mdl_cnt - 5'd1;
            if (mdl_cnt == 5'd1) rdy_int <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];
    int          start_cyc[$];
    logic [15:0] cur_rv = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sccb_start) begin
                start_cyc.push_back(cyc);
                check("start_with_ready", 32'(sccb_ready), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_start: got %0h with no write pending (cycle %0d)",
                             {sccb_reg, sccb_val}, cyc);
                end else begin
                    check("write_data", 32'({sccb_reg, sccb_val}), 32'(exp_q.pop_front()));
                end
                cur_rv = {sccb_reg, sccb_val};
            end else if (mdl_cnt != 0) begin
                check("hold_stable", 32'({sccb_reg, sccb_val}), 32'(cur_rv));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(output int s);
        s = cyc;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick(1);
            k++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic wait_starts(input int n, input int budget);
        int k = 0;
        while (start_cyc.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        check("start_seen", 32'(start_cyc.size() >= n), 32'd1);
    endtask

    task automatic load_rom(input logic [5:0][15:0] img);
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        for (int i = 0; i < 6; i++) rom_mem[i] = img[i];
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_sccb_start"}, 32'(sccb_start), 32'd0);
        check({tag, "_sccb_reg"}, 32'(sccb_reg), 32'd0);
        check({tag, "_sccb_val"}, 32'(sccb_val), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_write_count"}, 32'(write_count), 32'd0);
        check({tag, "_state"}, 32'(dut.state), 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [5:0][15:0] img;        // entries 5..0, entry 0 rightmost
        logic [7:0]       exp_count;
        logic [7:0]       exp_addr;
    } run_t;

    run_t runs[5];

    initial begin
        int s, r0, base;

        runs[0] = '{img: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1204, 16'hFFF0, 16'h1280}, exp_count: 8'd2, exp_addr: 8'd3};
        runs[1] = '{img: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, exp_count: 8'd0, exp_addr: 8'd0};
        runs[2] = '{img: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3A04, 16'hFFF0, 16'hFFF0}, exp_count: 8'd1, exp_addr: 8'd3};
        runs[3] = '{img: {16'hFFFF, 16'hFFFF, 16'h1400, 16'h1300, 16'h1200, 16'h1100}, exp_count: 8'd4, exp_addr: 8'd4};
        runs[4] = '{img: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFF0}, exp_count: 8'd0, exp_addr: 8'd1};

        rst = 1'b1;
        start = 1'b0;
        hold_low = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
        tick(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        tick(2);

        // Table-driven programs: writes go through the scoreboard, final outputs checked here.
        for (int r = 0; r < 5; r++) begin
            load_rom(runs[r].img);
            for (int i = 0; i < 6; i++) begin
                if (runs[r].img[i] == 16'hFFFF) break;
                if (runs[r].img[i] != 16'hFFF0) exp_q.push_back(runs[r].img[i]);
            end
            pulse_start(s);
            wait_done(2000);
            check("tbl_write_count", 32'(write_count), 32'(runs[r].exp_count));
            check("tbl_rom_addr", 32'(rom_addr), 32'(runs[r].exp_addr));
            check("tbl_busy", 32'(busy), 32'd0);
            check("tbl_pending", 32'(exp_q.size()), 32'd0);
            tick(2);
        end

        // Write latency, delay gap and start-while-busy.
        load_rom({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1204, 16'hFFF0, 16'h1280});
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1204);
        base = start_cyc.size();
        pulse_start(s);
        wait_starts(base + 1, 60);
        check("first_write_latency", 32'(start_cyc[base] - s), 32'd3);
        tick(3);
        pulse_start(r0);
        wait_done(500);
        check("gap_write1_write2", 32'(start_cyc[base + 1] - start_cyc[base]), 32'd38);
        check("busy_start_ignored", 32'(start_cyc.size() - base), 32'd2);
        check("s1_write_count", 32'(write_count), 32'd2);
        check("s1_busy", 32'(busy), 32'd0);

        // Replay after done.
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1204);
        pulse_start(s);
        check("replay_done_cleared", 32'(done), 32'd0);
        check("replay_busy", 32'(busy), 32'd1);
        wait_starts(base + 3, 60);
        tick(1);
        check("replay_count_restart", 32'(write_count), 32'd1);
        wait_done(500);
        check("replay_write_count", 32'(write_count), 32'd2);

        // Ready held low before the first write.
        load_rom({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h6622, 16'h5511});
        exp_q.push_back(16'h5511);
        exp_q.push_back(16'h6622);
        base = start_cyc.size();
        hold_low = 1'b1;
        pulse_start(s);
        tick(50);
        check("held_no_start", 32'(start_cyc.size() - base), 32'd0);
        check("held_busy", 32'(busy), 32'd1);
        hold_low = 1'b0;
        r0 = cyc;
        tick(1);
        check("release_one_start", 32'(start_cyc.size() - base), 32'd1);
        check("release_start_cycle", 32'(start_cyc[base]), 32'(r0));
        wait_done(500);
        check("held_write_count", 32'(write_count), 32'd2);

        // 256 plain entries: no wrap, write_count saturates.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] a;
            a = 8'(i);
            rom_mem[i] = {a, a ^ 8'hA5};
            exp_q.push_back({a, a ^ 8'hA5});
        end
        pulse_start(s);
        wait_done(10000);
        check("full_rom_addr", 32'(rom_addr), 32'd255);
        check("full_write_count", 32'(write_count), 32'd255);
        check("full_pending", 32'(exp_q.size()), 32'd0);

        // Reset during a delay entry.
        load_rom({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h1111, 16'hFFF0});
        base = start_cyc.size();
        pulse_start(s);
        tick(4);
        check("in_delay_state", 32'(dut.state), 32'd6);
        rst = 1'b1;
        tick(1);
        check_idle_outputs("midrst");
        rst = 1'b0;
        tick(20);
        check("no_start_after_rst", 32'(start_cyc.size() - base), 32'd0);
        exp_q.push_back(16'h1111);
        pulse_start(s);
        wait_done(500);
        check("after_rst_write_count", 32'(write_count), 32'd1);

`ifdef SCCB_TIMEOUT_EN
        // Watchdog: ready stuck low in WAIT_RDY.
        load_rom({16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h7788});
        hold_low = 1'b1;
        pulse_start(s);
        tick(101);
        check("wd_err_before", 32'(err), 32'd0);
        tick(1);
        check("wd_err", 32'(err), 32'd1);
        check("wd_busy", 32'(busy), 32'd0);
        check("wd_done", 32'(done), 32'd0);
        hold_low = 1'b0;
        tick(5);
        check("wd_idle_no_start", 32'(sccb_start), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "global timeout");
    end

endmodule
